csa_row_accumulator: RTL and testbench



---
 rtl/csa_pkg.sv | 22 ++
 rtl/csa_bit_cell.sv | 15 +
 rtl/csa_row_accumulator.sv | 168 ++++++++++++++++
 tb/tb_csa_row_accumulator.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save row accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CPA  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int PROD_W    = 2 * DEF_WIDTH;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  function automatic int cpa_cycles(input int width, input int chunk);
    return (2 * width) / chunk;
  endfunction

endpackage

// File: rtl/csa_bit_cell.sv
// Single-bit 3:2 compressor (full adder) used across the carry-save datapath.
// Latency: combinational.
// Backpressure: none, pure logic.
module csa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cy
);

  assign s  = a ^ b ^ c;
  assign cy = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_row_accumulator.sv
// Accumulates partial-product rows in carry-save form, then resolves them with a chunked CPA.
// Latency: start edge + ROWS accepted rows + 2*WIDTH/CPA_CHUNK CPA cycles, then out_valid.
// Backpressure: row_ready only in ACC; DONE holds product until out_ready (macro CSA_ROW_LAST_EN adds row_last).
module csa_row_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ROWS      = WIDTH,
  parameter int CPA_CHUNK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    row_valid,
  output logic                    row_ready,
  input  logic [WIDTH-1:0]        row_data,
`ifdef CSA_ROW_LAST_EN
  input  logic                    row_last,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH-1:0]      product,
  output logic                    busy
);

  localparam int PW  = prod_width(WIDTH);
  localparam int NCH = cpa_cycles(WIDTH, CPA_CHUNK);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((PW % CPA_CHUNK) != 0) begin : g_chunk_check
    $error("CPA_CHUNK must divide 2*WIDTH");
  end

  state_t state, state_nxt;

  logic [PW-1:0]        sum;
  logic [PW-1:0]        carry;
  logic [RW-1:0]        row_idx;
  logic [CW-1:0]        chunk_idx;
  logic                 cpa_c;

  logic [PW-1:0]        pp;
  logic [PW-1:0]        s_vec;
  logic [PW-1:0]        cy_vec;
  logic [PW-1:0]        carry_nxt;
  logic                 accept;
  logic                 last_row;
  logic                 cpa_last;
  logic [CPA_CHUNK-1:0] sum_chunk;
  logic [CPA_CHUNK-1:0] carry_chunk;
  logic [CPA_CHUNK:0]   chunk_res;

  // Row i carries weight 2^i, so align it before compressing.
  assign pp = {{(PW-WIDTH){1'b0}}, row_data} << row_idx;

  for (genvar i = 0; i < PW; i++) begin : g_cell
    csa_bit_cell u_cell (
      .a  (sum[i]),
      .b  (carry[i]),
      .c  (pp[i]),
      .s  (s_vec[i]),
      .cy (cy_vec[i])
    );
  end

  // The top majority bit would land beyond the product width; it is always zero for valid rows.
  wire unused_cy_msb = cy_vec[PW-1];
  assign carry_nxt = {cy_vec[PW-2:0], 1'b0};

  assign accept = row_valid & row_ready;

`ifdef CSA_ROW_LAST_EN
  assign last_row = (row_idx == RW'(ROWS-1)) | row_last;
`else
  assign last_row = (row_idx == RW'(ROWS-1));
`endif

  assign cpa_last = (chunk_idx == CW'(NCH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACC;
      end
      ACC: begin
        row_ready = 1'b1;
        if (row_valid && last_row) state_nxt = CPA;
      end
      CPA: begin
        if (cpa_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum_chunk   = '0;
    carry_chunk = '0;
    for (int k = 0; k < NCH; k++) begin
      if (chunk_idx == CW'(k)) begin
        sum_chunk   = sum[k*CPA_CHUNK +: CPA_CHUNK];
        carry_chunk = carry[k*CPA_CHUNK +: CPA_CHUNK];
      end
    end
  end

  assign chunk_res = {1'b0, sum_chunk} + {1'b0, carry_chunk} + {{CPA_CHUNK{1'b0}}, cpa_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry     <= '0;
      row_idx   <= '0;
      chunk_idx <= '0;
      cpa_c     <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum       <= '0;
            carry     <= '0;
            row_idx   <= '0;
            chunk_idx <= '0;
            cpa_c     <= 1'b0;
            product   <= '0;
          end
        end
        ACC: begin
          if (accept) begin
            sum     <= s_vec;
            carry   <= carry_nxt;
            row_idx <= row_idx + RW'(1);
          end
        end
        CPA: begin
          for (int k = 0; k < NCH; k++) begin
            if (chunk_idx == CW'(k)) begin
              product[k*CPA_CHUNK +: CPA_CHUNK] <= chunk_res[CPA_CHUNK-1:0];
            end
          end
          cpa_c     <= chunk_res[CPA_CHUNK];
          chunk_idx <= chunk_idx + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_row_accumulator.sv
// Directed bench for csa_row_accumulator: vector table plus stall, reset-abort and start-glitch sequences.
module tb_csa_row_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        row_valid = 1'b0;
  logic        row_ready;
  logic [7:0]  row_data = '0;
  logic        row_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csa_row_accumulator #(.WIDTH(8), .ROWS(8), .CPA_CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
`ifdef CSA_ROW_LAST_EN
    .row_last  (row_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start, then present nrows rows of x & {8{y[i]}}; cyc counts edges since the start edge.
  task automatic feed_rows(input logic [7:0] x, input logic [7:0] y, input int nrows,
                           input bit gaps, input bit glitch, output int cyc);
    logic [7:0] yy;
    yy = y;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < nrows; i++) begin
      row_valid = 1'b1;
      row_data  = x & {8{yy[i]}};
      row_last  = (i == nrows - 1);
      start     = glitch && (i == 3);
      @(negedge clk);
      cyc++;
      row_valid = 1'b0;
      row_last  = 1'b0;
      start     = 1'b0;
      row_data  = 8'hA5;
      if (gaps && i < nrows - 1) begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic wait_out(inout int cyc);
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake(input string name, input logic [15:0] exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " busy after handshake"}, {31'd0, busy}, 32'd0);
    chk({name, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
    chk({name, " product held in idle"}, {16'd0, product}, {16'd0, exp});
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    bit          gaps;
    logic [15:0] exp;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int cyc;
    string nm;

    vecs[0] = '{8'd13,  8'd11,  1'b0, 16'h008F, 13};
    vecs[1] = '{8'd255, 8'd255, 1'b1, 16'hFE01, 20};
    vecs[2] = '{8'd255, 8'd255, 1'b0, 16'hFE01, 13};
    vecs[3] = '{8'd7,   8'd6,   1'b0, 16'h002A, 13};
    vecs[4] = '{8'd0,   8'hA5,  1'b0, 16'h0000, 13};
    vecs[5] = '{8'd1,   8'd1,   1'b0, 16'h0001, 13};
    vecs[6] = '{8'd200, 8'd3,   1'b0, 16'h0258, 13};
    vecs[7] = '{8'h80,  8'h80,  1'b1, 16'h4000, 20};
    vecs[8] = '{8'hAA,  8'h55,  1'b0, 16'h3872, 13};

    #12;
    chk("reset row_ready", {31'd0, row_ready}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset product", {16'd0, product}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      nm = $sformatf("vec%0d", v);
      feed_rows(vecs[v].x, vecs[v].y, 8, vecs[v].gaps, 1'b0, cyc);
      wait_out(cyc);
      chk({nm, " latency"}, cyc, vecs[v].exp_lat);
      chk({nm, " product"}, {16'd0, product}, {16'd0, vecs[v].exp});
      handshake(nm, vecs[v].exp);
    end

    // Consumer stall: out_valid and product hold while out_ready is low.
    feed_rows(8'd13, 8'd11, 8, 1'b0, 1'b0, cyc);
    wait_out(cyc);
    chk("stall latency", cyc, 13);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d out_valid", s), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d product", s), {16'd0, product}, 32'h008F);
    end
    handshake("stall", 16'h008F);

    // Reset during the second CPA cycle aborts immediately.
    feed_rows(8'd13, 8'd11, 8, 1'b0, 1'b0, cyc);
    @(negedge clk);
    chk("pre-abort busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort row_ready", {31'd0, row_ready}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    feed_rows(8'd7, 8'd6, 8, 1'b0, 1'b0, cyc);
    wait_out(cyc);
    chk("post-abort latency", cyc, 13);
    chk("post-abort product", {16'd0, product}, 32'h002A);
    handshake("post-abort", 16'h002A);

    // start pulsed mid-ACC must not restart the operation.
    feed_rows(8'd0, 8'hFF, 8, 1'b0, 1'b1, cyc);
    wait_out(cyc);
    chk("glitch latency", cyc, 13);
    chk("glitch product", {16'd0, product}, 32'h0000);
    handshake("glitch", 16'h0000);
    @(negedge clk);
    chk("glitch stays idle", {31'd0, busy}, 32'd0);

`ifdef CSA_ROW_LAST_EN
    // Early termination after four rows.
    feed_rows(8'd13, 8'd11, 4, 1'b0, 1'b0, cyc);
    chk("last row_ready in cpa", {31'd0, row_ready}, 32'd0);
    wait_out(cyc);
    chk("last latency", cyc, 9);
    chk("last product", {16'd0, product}, 32'h008F);
    handshake("last", 16'h008F);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
